// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan path.
package seg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } scan_state_e;

  localparam int NIBBLE_W  = 4;
  localparam int FRAME_W   = 16;
  localparam int PWM_SLOTS = 8;
  localparam logic [NIBBLE_W-1:0] BLANK_CODE = 4'd10;

  // Digit 0 sits in the most significant nibble of a frame word.
  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [FRAME_W-1:0] frame,
                                                    input logic [1:0]         digit);
    logic [NIBBLE_W-1:0] nib;
    case (digit)
      2'd0:    nib = frame[15:12];
      2'd1:    nib = frame[11:8];
      2'd2:    nib = frame[7:4];
      2'd3:    nib = frame[3:0];
      default: nib = frame[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/pwm_slot_gen.sv
// Per-digit hold counter with eighth-slot brightness blanking; blank_o is
// registered and lines up with the cycle the counter value belongs to.
module pwm_slot_gen
  import seg_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       run_i,
  input  logic [2:0] brightness_i,
  output logic       tc_o,
  output logic       blank_o
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN_C = CNT_W'(HOLD_CYCLES / PWM_SLOTS);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] slot_s;
  logic             hold_next_s;
  logic             blank_next_s;
  logic             blank_r;

  // Next count, terminal detect and the blanking level for the next cycle.
  always_comb begin
    tc_o        = run_i && (cnt_r == CNT_LAST);
    hold_next_s = start_i || (run_i && !tc_o);
    if (start_i) begin
      cnt_next_s = '0;
    end else if (run_i && !tc_o) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
    slot_s = cnt_next_s / SLOT_LEN_C;
    if (hold_next_s) begin
      blank_next_s = (slot_s > CNT_W'(brightness_i));
    end else begin
      blank_next_s = 1'b1;
    end
  end

  // Counter and blanking registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r   <= '0;
      blank_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_next_s;
      blank_r <= blank_next_s;
    end
  end

  assign blank_o = blank_r;

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit refresh sequencer: per-digit load/transfer/hold with PWM
// blanking and frame-boundary arbitration between sources A and B.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [2:0]          brightness_i,
  input  logic [FRAME_W-1:0]  disp_a_i,
  input  logic                colon_a_i,
  input  logic                req_b_i,
  input  logic [FRAME_W-1:0]  disp_b_i,
  input  logic                colon_b_i,
  output logic                grant_b_o,
  input  logic                done_i,
  output logic                trigger_o,
  output logic [1:0]          digit_o,
  output logic [NIBBLE_W-1:0] nibble_o,
  output logic                colon_o,
  output logic                blank_o,
  output logic                frame_start_o
);

  localparam logic [1:0] DIGIT_LAST = 2'(NUM_DIGITS - 1);

  scan_state_e         state_r;
  scan_state_e         state_next_s;
  logic [1:0]          digit_r;
  logic [FRAME_W-1:0]  snap_r;
  logic                grant_b_r;
  logic [NIBBLE_W-1:0] nibble_r;
  logic                colon_r;
  logic                trigger_r;
  logic                frame_start_r;
  logic                hold_start_s;
  logic                hold_run_s;
  logic                hold_tc_s;
  logic                frame_load_s;
  logic [FRAME_W-1:0]  src_data_s;
  logic                src_colon_s;
  logic [NIBBLE_W-1:0] nibble_next_s;

  // Next-state logic plus source selection for the frame snapshot.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) state_next_s = ST_LOAD;
        else          state_next_s = ST_IDLE;
      end
      ST_LOAD: state_next_s = ST_SEND;
      ST_SEND: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (done_i) state_next_s = ST_HOLD;
        else        state_next_s = ST_WAIT;
      end
      ST_HOLD: begin
        if (!hold_tc_s)    state_next_s = ST_HOLD;
        else if (enable_i) state_next_s = ST_LOAD;
        else               state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase

    hold_start_s = (state_r == ST_WAIT) && done_i;
    hold_run_s   = (state_r == ST_HOLD);
    frame_load_s = (state_r == ST_LOAD) && (digit_r == 2'd0);
    if (req_b_i) begin
      src_data_s  = disp_b_i;
      src_colon_s = colon_b_i;
    end else begin
      src_data_s  = disp_a_i;
      src_colon_s = colon_a_i;
    end
    // Digit 0 reads the live source directly, since the snapshot lands on the same edge.
    if (frame_load_s) nibble_next_s = nibble_of(src_data_s, digit_r);
    else              nibble_next_s = nibble_of(snap_r, digit_r);
  end

  // State, digit index, snapshot and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      digit_r       <= 2'd0;
      snap_r        <= '0;
      grant_b_r     <= 1'b0;
      nibble_r      <= 4'd0;
      colon_r       <= 1'b0;
      trigger_r     <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      trigger_r     <= (state_r == ST_LOAD);
      frame_start_r <= frame_load_s;

      if ((state_r == ST_IDLE) && enable_i) begin
        digit_r <= 2'd0;
      end else if (hold_run_s && hold_tc_s) begin
        digit_r <= (digit_r == DIGIT_LAST) ? 2'd0 : digit_r + 2'd1;
      end else begin
        digit_r <= digit_r;
      end

      if (frame_load_s) begin
        grant_b_r <= req_b_i;
        snap_r    <= src_data_s;
        colon_r   <= src_colon_s;
      end else begin
        grant_b_r <= grant_b_r;
        snap_r    <= snap_r;
        colon_r   <= colon_r;
      end

      if (state_r == ST_LOAD) nibble_r <= nibble_next_s;
      else                    nibble_r <= nibble_r;
    end
  end

  pwm_slot_gen #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_pwm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (hold_start_s),
    .run_i        (hold_run_s),
    .brightness_i (brightness_i),
    .tc_o         (hold_tc_s),
    .blank_o      (blank_o)
  );

  assign grant_b_o     = grant_b_r;
  assign trigger_o     = trigger_r;
  assign digit_o       = digit_r;
  assign nibble_o      = nibble_r;
  assign colon_o       = colon_r;
  assign frame_start_o = frame_start_r;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller with HOLD_CYCLES=16 and a
// shift-register model that answers each trigger with a done pulse.
module tb_seg_scan_controller;

  localparam int HOLD = 16;
  localparam int DONE_DELAY = 3;
  localparam int BOUND = 2000;

  typedef struct packed {
    logic [1:0] digit;
    logic [3:0] nib;
    logic       grant;
    logic       colon;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic [15:0] disp_a = 16'h1234;
  logic        colon_a = 1'b1;
  logic        req_b = 1'b0;
  logic [15:0] disp_b = 16'h0000;
  logic        colon_b = 1'b0;
  logic        grant_b;
  logic        done_i = 1'b0;
  logic        trigger;
  logic [1:0]  digit;
  logic [3:0]  nibble;
  logic        colon;
  logic        blank;
  logic        frame_start;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   trig_count = 0;
  int   fs_count = 0;
  int   done_cd = 0;
  logic done_enable = 1'b1;
  logic manual_done = 1'b0;

  seg_scan_controller #(.HOLD_CYCLES(HOLD), .NUM_DIGITS(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .brightness_i(brightness),
    .disp_a_i(disp_a), .colon_a_i(colon_a), .req_b_i(req_b), .disp_b_i(disp_b),
    .colon_b_i(colon_b), .grant_b_o(grant_b), .done_i(done_i), .trigger_o(trigger),
    .digit_o(digit), .nibble_o(nibble), .colon_o(colon), .blank_o(blank),
    .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic exp_push(input logic [1:0] d, input logic [3:0] n, input logic g, input logic c);
    exp_t e;
    e.digit = d; e.nib = n; e.grant = g; e.colon = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_trig(input int n);
    int k = 0;
    while (trig_count < n && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    if (trig_count < n) timeout("wait_trig");
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!done_i && k < BOUND);
    if (!done_i) timeout("wait_done");
  endtask

  task automatic measure_hold(input string name, input logic [15:0] exp);
    logic [15:0] v;
    wait_done();
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      v[i] = blank;
    end
    chk(name, {16'd0, v}, {16'd0, exp});
    @(negedge clk);
    chk("blank_after_hold", {31'd0, blank}, 32'd1);
  endtask

  // Shift-register model: done pulse DONE_DELAY negedges after each trigger.
  always @(negedge clk) begin
    done_i = 1'b0;
    if (manual_done) begin
      done_i = 1'b1;
    end else if (done_cd == 1) begin
      done_i = 1'b1;
      done_cd = 0;
    end else if (done_cd > 1) begin
      done_cd = done_cd - 1;
    end
    if (trigger && done_enable && !rst) done_cd = DONE_DELAY;
  end

  // Monitor: each trigger pops one expected digit from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && trigger) begin
      trig_count++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_trigger actual=digit %0d nibble %0h expected=no trigger", digit, nibble);
      end else begin
        e = exp_q.pop_front();
        chk("trigger_fields", {24'd0, digit, nibble, grant_b, colon}, {24'd0, e});
      end
    end
    if (!rst && frame_start) begin
      fs_count++;
      chk("frame_start_digit", {30'd0, digit}, 32'd0);
    end
  end

  initial begin
    logic all_blank;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_blank", {31'd0, blank}, 32'd1);
    chk("rst_trigger", {31'd0, trigger}, 32'd0);
    chk("rst_digit", {30'd0, digit}, 32'd0);
    chk("rst_nibble", {28'd0, nibble}, 32'd0);
    chk("rst_grant", {31'd0, grant_b}, 32'd0);
    chk("rst_colon", {31'd0, colon}, 32'd0);

    // Frame 1: source A 1234, brightness 7 on digit 0, then brightness 1.
    exp_push(2'd0, 4'h1, 1'b0, 1'b1);
    exp_push(2'd1, 4'h2, 1'b0, 1'b1);
    exp_push(2'd2, 4'h3, 1'b0, 1'b1);
    exp_push(2'd3, 4'h4, 1'b0, 1'b1);
    enable = 1'b1;
    rst = 1'b0;
    measure_hold("hold_bright7", 16'h0000);
    brightness = 3'd1;

    // A changes mid-frame: frame 1 keeps 3,4; frame 2 shows 5678.
    wait_trig(2);
    disp_a = 16'h5678;
    exp_push(2'd0, 4'h5, 1'b0, 1'b1);
    exp_push(2'd1, 4'h6, 1'b0, 1'b1);
    exp_push(2'd2, 4'h7, 1'b0, 1'b1);
    exp_push(2'd3, 4'h8, 1'b0, 1'b1);
    measure_hold("hold_bright1", 16'hFFF0);

    // B requested during digit 2 of frame 2: takes over from frame 3.
    wait_trig(7);
    disp_b = 16'hAA59;
    colon_b = 1'b0;
    req_b = 1'b1;
    exp_push(2'd0, 4'hA, 1'b1, 1'b0);
    exp_push(2'd1, 4'hA, 1'b1, 1'b0);
    exp_push(2'd2, 4'h5, 1'b1, 1'b0);
    exp_push(2'd3, 4'h9, 1'b1, 1'b0);
    @(negedge clk);
    chk("grant_mid_frame", {31'd0, grant_b}, 32'd0);

    // Frame 4 digit 0: done withheld for 100 cycles.
    wait_trig(12);
    req_b = 1'b0;
    done_enable = 1'b0;
    exp_push(2'd0, 4'h5, 1'b0, 1'b1);
    wait_trig(13);
    all_blank = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      all_blank = all_blank & blank;
    end
    chk("wait_blank", {31'd0, all_blank}, 32'd1);
    chk("wait_no_retrigger", trig_count, 32'd13);
    manual_done = 1'b1;
    wait_done();
    manual_done = 1'b0;
    done_enable = 1'b1;
    @(negedge clk);
    chk("hold_after_done", {31'd0, blank}, 32'd0);

    // Disable during digit 1: parks in IDLE, dark, no more triggers.
    exp_push(2'd1, 4'h6, 1'b0, 1'b1);
    wait_trig(14);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    all_blank = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      all_blank = all_blank & blank;
    end
    chk("idle_blank", {31'd0, all_blank}, 32'd1);
    chk("idle_no_trigger", trig_count, 32'd14);

    // Re-enable restarts at digit 0; reset during the hold of digit 2.
    exp_push(2'd0, 4'h5, 1'b0, 1'b1);
    exp_push(2'd1, 4'h6, 1'b0, 1'b1);
    exp_push(2'd2, 4'h7, 1'b0, 1'b1);
    enable = 1'b1;
    wait_trig(17);
    wait_done();
    repeat (2) @(negedge clk);
    chk("hold_lit_before_rst", {31'd0, blank}, 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_blank", {31'd0, blank}, 32'd1);
    chk("midrst_digit", {30'd0, digit}, 32'd0);
    chk("midrst_nibble", {28'd0, nibble}, 32'd0);
    chk("midrst_colon", {31'd0, colon}, 32'd0);
    chk("midrst_trigger", {31'd0, trigger}, 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("trigger_total", trig_count, 32'd17);
    chk("frame_start_total", fs_count, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Sequences the four-digit multiplexed refresh of the 7-segment display: it selects the digit, presents its nibble and colon to the segment encoder, triggers the 595 shift-register transfer, waits for completion, and holds each digit for a programmable time with PWM brightness blanking. It also arbitrates between two display sources: the clock time view (A) and an override view (B, e.g. seconds or set-mode). It sits between the clock counters and the `seg7x4withColon` → `shift_register_595` datapath.

## Interface

Parameters:
- `HOLD_CYCLES`, default 1024: clock cycles each digit stays latched after transfer completes; must be a multiple of 8 and at least 8.
- `NUM_DIGITS`, default 4: digits per frame; fixed at 4 in this revision.

Ports:
- `clk_i` input 1: system clock, the single clock domain.
- `rst_i` input 1: reset, asynchronous, active-high.
- `enable_i` input 1: scanning enabled; when low, the FSM finishes the current digit and parks in IDLE.
- `brightness_i` input 3: lit fraction of hold time, in eighths minus one (0 = 1/8, 7 = 8/8).
- `disp_a_i` input 16: source A nibbles; [15:12] is digit 0 … [3:0] is digit 3.
- `colon_a_i` input 1: source A colon.
- `req_b_i` input 1: source B request (level).
- `disp_b_i` input 16: source B nibbles, same packing as A.
- `colon_b_i` input 1: source B colon.
- `grant_b_o` output 1: source B owns the current frame.
- `done_i` input 1: one-cycle pulse from the shift register when the latch completes.
- `trigger_o` output 1: one-cycle transfer start pulse to the shift register.
- `digit_o` output 2: digit index to the encoder.
- `nibble_o` output 4: value for the current digit.
- `colon_o` output 1: colon for the current frame.
- `blank_o` output 1: drives the 595 /OE; 1 = display dark.
- `frame_start_o` output 1: one-cycle pulse when digit 0 is loaded.

## Operation

FSM states: IDLE, LOAD, SEND, WAIT, HOLD.
- **IDLE**: `blank_o` = 1. If `enable_i` = 1, go to LOAD with digit = 0.
- **LOAD**: if digit = 0, take a frame snapshot:
  - Arbitrate: `grant_b_o` ← `req_b_i`.
  - Copy the granted source's 16-bit data and colon into internal registers.
  - Pulse `frame_start_o`.
  - Then, for any digit, drive `nibble_o` ← snapshot[digit] and go to SEND.
- **SEND**: `trigger_o` = 1 for exactly one cycle, then WAIT.
- **WAIT**: stay until `done_i` = 1. Then clear the hold counter and go to HOLD.
- **HOLD**: count 0..`HOLD_CYCLES`-1.
  - Slot = count / (`HOLD_CYCLES`/8). `blank_o` = 1 when slot > `brightness_i`, else 0.
  - At terminal count: digit wraps 3 → 0. If `enable_i` = 0, go to IDLE; else go to LOAD.
- Arbitration happens only at the frame boundary. Changes in `req_b_i` or source data mid-frame have no effect until the next digit-0 LOAD. This prevents tearing.
- `blank_o` = 1 in LOAD, SEND and WAIT, so the old segment pattern is never shown against the new digit.
- `brightness_i` is sampled live every cycle; a change takes effect within the current hold.
- A `done_i` pulse outside WAIT is ignored.

## Timing

- Reset values: state IDLE, digit 0, `trigger_o` 0, `blank_o` 1, `grant_b_o` 0, `nibble_o` 0, `colon_o` 0, `frame_start_o` 0, snapshot 0.
- Asserting `rst_i` mid-operation returns to IDLE immediately; any in-flight transfer is abandoned.
- Per-digit latency: LOAD 1 cycle, SEND 1 cycle, WAIT ≥ 1 cycle, HOLD `HOLD_CYCLES` cycles.
- `trigger_o` rises the cycle after LOAD. WAIT exits the cycle after `done_i` is sampled high.
- `digit_o` and `nibble_o` are registered and stable from LOAD until the next LOAD.
- `done_i` arriving in the same cycle as `trigger_o` is not counted; the FSM waits for a pulse in WAIT.
- Frame period = 4 × (3 + `HOLD_CYCLES` + shift time − 1) cycles.

## Structure

- Shared package `seg_pkg`:
  - FSM state enum.
  - Nibble-extract constants.
  - Blank code 4'd10, which the encoder already decodes.
- One natural sub-module: `pwm_slot_gen` (hold counter, slot compare, `blank_o`).
- Expected RTL size ≈ 150–250 lines.

## Test plan

- Reset release with `enable_i`=1, A=16'h1234, `HOLD_CYCLES`=16, `done_i` 3 cycles after each trigger → `digit_o`/`nibble_o` sequence 0/1, 1/2, 2/3, 3/4; exactly 4 `trigger_o` pulses per frame; `frame_start_o` only with digit 0.
- `brightness_i`=1, `HOLD_CYCLES`=16 → `blank_o` low for 4 cycles, then high for 12 cycles of each HOLD; `brightness_i`=7 → low for all 16.
- `req_b_i` rises during digit 2 with B=16'hAA59 → frame finishes with A data; next frame digits read A,A,5,9 and `grant_b_o`=1 for the whole frame.
- A changed from 16'h1234 to 16'h5678 during digit 1 → remaining digits still show 3,4; the next frame shows 5,6,7,8.
- `done_i` withheld for 100 cycles → FSM stays in WAIT, `blank_o`=1, no second trigger; `done_i` pulse → HOLD the next cycle.
- `rst_i` pulsed in HOLD of digit 2, and `enable_i` dropped in digit 1 → immediate reset values; disable parks in IDLE after digit 1's hold with `blank_o`=1.
